// File: rtl/disp_arbiter.sv
// Round-robin sharing of the 8-digit display among N_REQ requesters; a granted word is held >= HOLD_CNT unfrozen cycles.
// Latency: ack/disp_word one edge after a qualifying req. Backpressure: requests wait (level) while a word is being held or frozen.
`timescale 1ns/1ps
module disp_arbiter #(
    parameter int          N_REQ        = 4,
    parameter int          HOLD_CNT     = 50000000,
    parameter logic [31:0] DEFAULT_WORD = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [32*N_REQ-1:0]   data,
    input  logic                  freeze,
    output logic [N_REQ-1:0]      ack,
    output logic [31:0]           disp_word,
    output logic [2:0]            disp_src,
    output logic                  disp_valid,
    output logic                  busy
);
    localparam int             CW       = (HOLD_CNT > 1) ? $clog2(HOLD_CNT) : 1;
    localparam logic [CW-1:0]  CNT_LOAD = CW'(HOLD_CNT - 1);
    localparam logic [2:0]     PTR_RST  = 3'(N_REQ - 1);

    typedef enum logic {IDLE, SHOW} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic [31:0]       word_q, word_d;
    logic [2:0]        src_q, src_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic [2:0]        ptr_q, ptr_d;

    logic              gnt_found;
    logic [2:0]        gnt_idx;
    logic              grant_en;
    int                idx_v;

    // Scan starts one past the last winner so every requester gets a turn.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx_v     = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx_v = (int'(ptr_q) + k) % N_REQ;
            if (!gnt_found && req[idx_v]) begin
                gnt_found = 1'b1;
                gnt_idx   = 3'(idx_v);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ack_d    = '0;
        word_d   = word_q;
        src_d    = src_q;
        valid_d  = valid_q;
        ptr_d    = ptr_q;
        grant_en = 1'b0;
        case (state_q)
            IDLE: grant_en = gnt_found;
            SHOW: begin
                if (!freeze) begin
                    if (cnt_q != '0)
                        cnt_d = cnt_q - 1'b1;
                    else if (gnt_found)
                        grant_en = 1'b1;
                    else
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (grant_en) begin
            ack_d   = {{(N_REQ-1){1'b0}}, 1'b1} << gnt_idx;
            word_d  = data[32*int'(gnt_idx) +: 32];
            src_d   = gnt_idx;
            ptr_d   = gnt_idx;
            valid_d = 1'b1;
            cnt_d   = CNT_LOAD;
            state_d = SHOW;
        end
        busy_d = (state_d == SHOW);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ack_q   <= '0;
            word_q  <= DEFAULT_WORD;
            src_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ptr_q   <= PTR_RST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            word_q  <= word_d;
            src_q   <= src_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
        end
    end

    assign ack        = ack_q;
    assign disp_word  = word_q;
    assign disp_src   = src_q;
    assign disp_valid = valid_q;
    assign busy       = busy_q;
endmodule
